mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MUL_CYCLES, default 5: multiply latency in cycles.
REQ-002 Parameter DIV_CYCLES, default 10: divide latency in cycles.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request qualifier; op/A/B are sampled on the edge where start=1.
REQ-006 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6-7 reserved, treated as no-op.
REQ-007 A  input  32  rs operand, taken from register-file read port 1 (bypassed value).
REQ-008 B  input  32  rt operand, taken from register-file read port 2 (bypassed value).
REQ-009 busy  output  1  a multiply or divide is in flight.
REQ-010 stall  output  1  combinational: busy | (start & op is MULT/MULTU/DIV/DIVU); drives the hazard unit.
REQ-011 HI  output  32  HI register, registered.
REQ-012 LO  output  32  LO register, registered.

Function
REQ-013 The FSM SHALL have three states: IDLE, MUL, DIV.
- Reset state: IDLE.
REQ-014 In IDLE, start with MULT/MULTU SHALL latch the full 64-bit product into a pending register, load the counter with MUL_CYCLES, and enter MUL.
REQ-015 In IDLE, start with DIV/DIVU SHALL latch the quotient and remainder into the pending register, load the counter with DIV_CYCLES, and enter DIV.
REQ-016 busy SHALL be 1 exactly in MUL and DIV.
- busy rises on the start edge and stays high for exactly N cycles.
REQ-017 The counter SHALL decrement once per cycle.
- On the edge where it reaches 1: HI/LO are committed from the pending register, busy falls, and the FSM returns to IDLE.
- HI/LO are therefore visible N cycles after the start edge.
REQ-018 MULT SHALL be signed 32x32->64 and MULTU unsigned; {HI,LO} = product.
REQ-019 DIV/DIVU SHALL set LO = quotient and HI = remainder.
- Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-021 Divide by zero (B=0) SHALL run the full DIV_CYCLES with busy high, then leave HI and LO unchanged.
REQ-022 MTHI/MTLO in IDLE SHALL write A into HI/LO on the sampled edge.
- No busy and no stall.
REQ-023 start while busy=1 SHALL be ignored: no state, counter, or HI/LO change.
- The hazard unit guarantees this does not occur legitimately.
REQ-024 start with a reserved op SHALL be ignored.
REQ-025 HI/LO SHALL hold their value in all cycles other than a commit edge or an MTHI/MTLO edge.
REQ-026 During MUL/DIV, HI/LO outputs SHALL show the old values, never partial results.

Reset
REQ-027 reset=0 SHALL immediately force, independent of clk:
- FSM to IDLE, counter to 0, busy to 0;
- HI, LO, and the pending register to 0.
REQ-028 Reset asserted mid-operation SHALL discard the pending result.
- After release, the block SHALL accept a new start on the first rising edge.

Structure
REQ-029 The op encodings and the MUL_CYCLES/DIV_CYCLES defaults SHALL reside in the shared MIPS definitions package.
- The decoder and the hazard unit use the same package.
REQ-030 Single module; no sub-module.
- Product and quotient are computed combinationally at start, and the counter models the latency.
- A future iterative divider SHALL replace this as sub-module mdu_div with the same latency contract.

Verification
REQ-031 MULT A=0xFFFFFFFE (-2), B=3:
- stall=1 in the start cycle; busy high for 5 cycles;
- then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 DIVU A=100, B=7, then DIV A=0xFFFFFFF9 (-7), B=2:
- first: after 10 cycles HI=2, LO=14;
- second: HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-033 DIV A=5, B=0 with prior HI=0x11, LO=0x22:
- busy for 10 cycles; then HI=0x11, LO=0x22.
REQ-034 MTHI A=0xDEADBEEF:
- HI=0xDEADBEEF one edge later; busy and stall never asserted.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF:
- a second start (MTLO) at cycle 2 is ignored;
- HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 Reset asserted at cycle 3 of a DIV:
- busy=0 and HI=LO=0 immediately;
- a new MULT 6x7 after release gives LO=42 in 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MIPS multiply/divide definitions: op encodings, default latencies, FSM states.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int unsigned MDU_MUL_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } mdu_state_e;

  // True for ops that occupy the unit for several cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// MIPS HI/LO multiply/divide unit. Results are computed combinationally when
// the request is sampled; a down-counter models the pipeline latency before
// HI/LO are committed.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MDU_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  mdu_state_e    state;
  logic [CW-1:0] cnt;
  logic [63:0]   pend;
  logic          pend_ok;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   divisor;
  logic [31:0]   quo;
  logic [31:0]   rem;

  // Full-width products and quotient/remainder of the current operands.
  always_comb begin
    prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u  = {32'b0, A} * {32'b0, B};
    // Divisor forced nonzero so the datapath never produces X; a zero divide
    // is suppressed at commit time instead.
    divisor = (B == '0) ? 32'd1 : B;
    quo     = '0;
    rem     = '0;
    if (op == OP_DIVU) begin
      quo = A / divisor;
      rem = A % divisor;
    end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = '0;
    end else begin
      quo = $unsigned($signed(A) / $signed(divisor));
      rem = $unsigned($signed(A) % $signed(divisor));
    end
  end

  // Hazard request: busy, or a multi-cycle op being issued this cycle.
  always_comb begin
    stall = busy | (start & is_muldiv(op));
  end

  // Control FSM with latency counter and HI/LO commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      pend    <= '0;
      pend_ok <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                pend    <= (op == OP_MULT) ? prod_s : prod_u;
                pend_ok <= 1'b1;
                cnt     <= CW'(MUL_CYCLES);
                busy    <= 1'b1;
                state   <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                pend    <= {rem, quo};
                pend_ok <= (B != '0);
                cnt     <= CW'(DIV_CYCLES);
                busy    <= 1'b1;
                state   <= ST_DIV;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == CW'(1)) begin
            if (pend_ok) begin
              {HI, LO} <= pend;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
